// File: rtl/input_manager_if.sv
// Player-input bundle: raw buttons and game tick toward the input manager,
// and registered key pulses back out.
interface input_manager_if;
  logic tick_game;
  logic btn_left;
  logic btn_right;
  logic btn_down;
  logic btn_rotate;
  logic btn_drop;
  logic btn_hold;
  logic key_left;
  logic key_right;
  logic key_down;
  logic key_rotate;
  logic key_drop;
  logic key_hold;
  logic key_drop_held;

  modport master (
    output tick_game, btn_left, btn_right, btn_down, btn_rotate, btn_drop, btn_hold,
    input  key_left, key_right, key_down, key_rotate, key_drop, key_hold, key_drop_held
  );

  modport slave (
    input  tick_game, btn_left, btn_right, btn_down, btn_rotate, btn_drop, btn_hold,
    output key_left, key_right, key_down, key_rotate, key_drop, key_hold, key_drop_held
  );
endinterface

// File: rtl/input_manager.sv
// Synchronizes and debounces six raw buttons, then turns them into one-clk key
// pulses with DAS/ARR auto-repeat on left/right and soft-drop repeat on down.
module input_manager #(
  parameter int unsigned DEBOUNCE_CYCLES  = 100000,
  parameter int unsigned DAS_FRAMES       = 10,
  parameter int unsigned ARR_FRAMES       = 2,
  parameter int unsigned SOFT_DROP_FRAMES = 3
) (
  input logic             i_clk,
  input logic             i_rst,
  input_manager_if.slave  bus
);

  localparam int unsigned KLeft   = 0;
  localparam int unsigned KRight  = 1;
  localparam int unsigned KDown   = 2;
  localparam int unsigned KRotate = 3;
  localparam int unsigned KDrop   = 4;
  localparam int unsigned KHold   = 5;

  localparam logic [19:0] DbLimit   = 20'(DEBOUNCE_CYCLES);
  localparam logic [7:0]  DasLimit  = 8'(DAS_FRAMES);
  localparam logic [7:0]  ArrLimit  = 8'(ARR_FRAMES);
  localparam logic [7:0]  SoftLimit = 8'(SOFT_DROP_FRAMES);

  typedef enum logic [1:0] {StIdle, StDas, StRepeat} dir_st_e;
  typedef enum logic {StDnIdle, StDnRepeat} down_st_e;

  typedef struct packed {
    dir_st_e    st;
    logic [7:0] cnt;
    logic       pulse;
  } dir_t;

  logic [5:0]       w_btn;
  logic [5:0]       r_sync1, r_sync2, r_db, r_db_prev;
  logic [5:0][19:0] r_db_cnt;
  logic [5:0]       w_rise;

  dir_t       r_left, r_right, w_left_d, w_right_d;
  down_st_e   r_down_st, w_down_st_d;
  logic [7:0] r_down_cnt, w_down_cnt_d;
  logic       r_key_down, w_key_down_d;
  logic       r_key_rotate, r_key_drop, r_key_hold, r_drop_held;

  assign w_btn = {bus.btn_hold, bus.btn_drop, bus.btn_rotate,
                  bus.btn_down, bus.btn_right, bus.btn_left};

  // Debounced state flips only after DEBOUNCE_CYCLES unbroken mismatch cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= w_btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 6; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DbLimit) begin
            r_db[i]     <= ~r_db[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_rise = r_db & ~r_db_prev;

  // A kill (rise on the opposite direction) parks the FSM in idle until its own re-press.
  function automatic dir_t dir_next(dir_t cur, logic db, logic rise, logic kill, logic tick);
    dir_t nxt;
    nxt       = cur;
    nxt.pulse = 1'b0;
    if (rise) begin
      nxt.st    = StDas;
      nxt.cnt   = '0;
      nxt.pulse = 1'b1;
    end else if (kill || !db) begin
      nxt.st  = StIdle;
      nxt.cnt = '0;
    end else if (cur.st != StIdle && tick) begin
      if (cur.cnt + 8'd1 == ((cur.st == StDas) ? DasLimit : ArrLimit)) begin
        nxt.st    = StRepeat;
        nxt.cnt   = '0;
        nxt.pulse = 1'b1;
      end else begin
        nxt.cnt = cur.cnt + 8'd1;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    w_left_d  = dir_next(r_left, r_db[KLeft], w_rise[KLeft], w_rise[KRight], bus.tick_game);
    w_right_d = dir_next(r_right, r_db[KRight], w_rise[KRight] & ~w_rise[KLeft],
                         w_rise[KLeft], bus.tick_game);
  end

  always_comb begin
    w_down_st_d  = r_down_st;
    w_down_cnt_d = r_down_cnt;
    w_key_down_d = 1'b0;
    if (w_rise[KDown]) begin
      w_down_st_d  = StDnRepeat;
      w_down_cnt_d = '0;
      w_key_down_d = 1'b1;
    end else if (!r_db[KDown]) begin
      w_down_st_d  = StDnIdle;
      w_down_cnt_d = '0;
    end else if (r_down_st == StDnRepeat && bus.tick_game) begin
      if (r_down_cnt + 8'd1 == SoftLimit) begin
        w_down_cnt_d = '0;
        w_key_down_d = 1'b1;
      end else begin
        w_down_cnt_d = r_down_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_left       <= '{st: StIdle, cnt: 8'd0, pulse: 1'b0};
      r_right      <= '{st: StIdle, cnt: 8'd0, pulse: 1'b0};
      r_down_st    <= StDnIdle;
      r_down_cnt   <= '0;
      r_key_down   <= 1'b0;
      r_key_rotate <= 1'b0;
      r_key_drop   <= 1'b0;
      r_key_hold   <= 1'b0;
      r_drop_held  <= 1'b0;
    end else begin
      r_left       <= w_left_d;
      r_right      <= w_right_d;
      r_down_st    <= w_down_st_d;
      r_down_cnt   <= w_down_cnt_d;
      r_key_down   <= w_key_down_d;
      r_key_rotate <= w_rise[KRotate];
      r_key_drop   <= w_rise[KDrop];
      r_key_hold   <= w_rise[KHold];
      r_drop_held  <= r_db[KDrop];
    end
  end

  assign bus.key_left      = r_left.pulse;
  assign bus.key_right     = r_right.pulse;
  assign bus.key_down      = r_key_down;
  assign bus.key_rotate    = r_key_rotate;
  assign bus.key_drop      = r_key_drop;
  assign bus.key_hold      = r_key_hold;
  assign bus.key_drop_held = r_drop_held;

endmodule

// File: tb/tb_input_manager.sv
// Directed bench for input_manager: a vector table for press/glitch/conflict
// cases plus hand-timed sequences for latency, auto-repeat and reset.
module tb_input_manager;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned DasFrames = 10;
  localparam int unsigned ArrFrames = 2;
  localparam int unsigned SoftFrames = 3;

  // Button / key index: 0 left, 1 right, 2 down, 3 rotate, 4 drop, 5 hold
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] btn = '0;
  logic [5:0] keys;
  int         tick_div = 0;
  int         n_key [6];
  int         n_tick = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  input_manager_if bus ();

  assign bus.tick_game  = tick;
  assign bus.btn_left   = btn[0];
  assign bus.btn_right  = btn[1];
  assign bus.btn_down   = btn[2];
  assign bus.btn_rotate = btn[3];
  assign bus.btn_drop   = btn[4];
  assign bus.btn_hold   = btn[5];
  assign keys = {bus.key_hold, bus.key_drop, bus.key_rotate,
                 bus.key_down, bus.key_right, bus.key_left};

  input_manager #(
    .DEBOUNCE_CYCLES  (DebCycles),
    .DAS_FRAMES       (DasFrames),
    .ARR_FRAMES       (ArrFrames),
    .SOFT_DROP_FRAMES (SoftFrames)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One-clk game tick every 20 clocks, changed just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div == 19) ? 0 : tick_div + 1;
      tick = (tick_div == 19);
    end
  end

  // Pulse and tick counters, sampled mid-cycle
  initial begin
    for (int k = 0; k < 6; k++) n_key[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) if (keys[k] === 1'b1) n_key[k] = n_key[k] + 1;
      if (tick === 1'b1) n_tick = n_tick + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sync_tick();
    int g = 0;
    do begin
      step();
      g++;
    end while (tick !== 1'b1 && g < 40);
    check("tick_seen", int'(tick === 1'b1), 1);
  endtask

  // Wait until n more ticks have gone by, then let the resulting pulse land
  task automatic wait_ticks(input int n);
    int start = n_tick;
    int g = 0;
    while (n_tick - start < n && g < n * 20 + 60) begin
      step();
      g++;
    end
    if (n_tick - start < n) check("wait_ticks_timeout", n_tick - start, n);
    step();
    step();
  endtask

  typedef struct {
    string            name;
    logic [5:0]       btn;
    int               hold;
    logic [5:0][3:0]  exp;  // expected pulses per key, [5]=hold .. [0]=left
  } vec_t;

  localparam int NVec = 11;
  vec_t vecs [NVec];
  int   base [6];
  int   sum0;

  initial begin
    vecs[0]  = '{"rotate_500",    6'b001000, 500, {4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0}};
    vecs[1]  = '{"rotate_glitch3", 6'b001000, 3,  {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[2]  = '{"hold_glitch3",  6'b100000, 3,   {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[3]  = '{"hold_glitch4",  6'b100000, 4,   {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[4]  = '{"hold_pulse5",   6'b100000, 5,   {4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
    vecs[5]  = '{"edge_trio",     6'b111000, 50,  {4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0}};
    vecs[6]  = '{"left_short",    6'b000001, 30,  {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1}};
    vecs[7]  = '{"left_right_sim", 6'b000011, 30, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1}};
    vecs[8]  = '{"right_short",   6'b000010, 30,  {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
    vecs[9]  = '{"down_short",    6'b000100, 30,  {4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0}};
    vecs[10] = '{"drop_pulse5",   6'b010000, 5,   {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};

    // Reset asserted between edges clears outputs without waiting for a clock
    #22;
    rst = 1'b1;
    #1;
    check("reset_async_outputs", int'({bus.key_drop_held, keys}), 0);
    repeat (3) step();
    rst = 1'b0;
    sum0 = n_key[0] + n_key[1] + n_key[2] + n_key[3] + n_key[4] + n_key[5];
    repeat (1000) step();
    check("reset_idle_pulses",
          n_key[0] + n_key[1] + n_key[2] + n_key[3] + n_key[4] + n_key[5] - sum0, 0);
    check("reset_idle_held", int'(bus.key_drop_held), 0);

    // Press latency: pulse only in the cycle after edge DebCycles+3
    base[3] = n_key[3];
    btn[3] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 7) check("rotate_before_edge7", int'(bus.key_rotate), 0);
      if (c == 8) check("rotate_after_edge7", int'(bus.key_rotate), 1);
      if (c == 9) check("rotate_one_cycle", int'(bus.key_rotate), 0);
    end
    repeat (491) step();
    check("rotate_held_single", n_key[3] - base[3], 1);
    btn[3] = 1'b0;
    repeat (20) step();
    btn[3] = 1'b1;
    repeat (20) step();
    check("rotate_repress", n_key[3] - base[3], 2);
    btn[3] = 1'b0;
    repeat (20) step();

    // Table of press/hold/release vectors
    for (int v = 0; v < NVec; v++) begin
      for (int k = 0; k < 6; k++) base[k] = n_key[k];
      btn = vecs[v].btn;
      repeat (vecs[v].hold) step();
      btn = '0;
      repeat (40) step();
      for (int k = 0; k < 6; k++)
        check($sformatf("%s_key%0d", vecs[v].name, k), n_key[k] - base[k], int'(vecs[v].exp[k]));
    end

    // Left auto-repeat: press, DAS at tick 10, then every 2 ticks
    sync_tick();
    base[0] = n_key[0];
    btn[0] = 1'b1;
    wait_ticks(9);
    check("left_before_das", n_key[0] - base[0], 1);
    wait_ticks(1);
    check("left_das_tick10", n_key[0] - base[0], 2);
    wait_ticks(10);
    check("left_20_ticks", n_key[0] - base[0], 7);
    btn[0] = 1'b0;
    wait_ticks(5);
    check("left_after_release", n_key[0] - base[0], 7);

    // Newest press wins; released right does not revive held left
    sync_tick();
    base[0] = n_key[0];
    base[1] = n_key[1];
    btn[0] = 1'b1;
    wait_ticks(12);
    check("conflict_left_das", n_key[0] - base[0], 3);
    btn[1] = 1'b1;
    wait_ticks(6);
    check("conflict_left_stopped", n_key[0] - base[0], 3);
    check("conflict_right_pulse", n_key[1] - base[1], 1);
    btn[1] = 1'b0;
    wait_ticks(30);
    check("conflict_left_suppressed", n_key[0] - base[0], 3);
    check("conflict_right_quiet", n_key[1] - base[1], 1);
    btn[0] = 1'b0;
    repeat (20) step();

    // Soft drop: press plus every 3 ticks
    sync_tick();
    base[2] = n_key[2];
    btn[2] = 1'b1;
    wait_ticks(9);
    check("down_9_ticks", n_key[2] - base[2], 4);
    btn[2] = 1'b0;
    wait_ticks(3);
    check("down_after_release", n_key[2] - base[2], 4);

    // Drop held through a reset
    base[4] = n_key[4];
    btn[4] = 1'b1;
    repeat (10) step();
    check("drop_press_pulse", n_key[4] - base[4], 1);
    check("drop_held_high", int'(bus.key_drop_held), 1);
    #2;
    rst = 1'b1;
    #1;
    check("drop_held_reset_async", int'(bus.key_drop_held), 0);
    repeat (2) step();
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 7) begin
        check("drop_rst_before_edge7", int'(bus.key_drop), 0);
        check("drop_rst_held_low", int'(bus.key_drop_held), 0);
      end
      if (c == 8) begin
        check("drop_rst_repulse", int'(bus.key_drop), 1);
        check("drop_rst_held_back", int'(bus.key_drop_held), 1);
      end
      if (c == 9) check("drop_rst_one_cycle", int'(bus.key_drop), 0);
    end
    btn[4] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 7) check("drop_release_before", int'(bus.key_drop_held), 1);
      if (c == 8) check("drop_release_edge7", int'(bus.key_drop_held), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_manager.md
# input_manager

Front end of the player-input path. It takes six raw, asynchronous buttons and produces the single-cycle key pulses that the game FSM consumes (`key_left` … `key_hold`), plus the level signal `key_drop_held` used for hard-drop lockout. Per button it provides synchronization and debounce. Left, right and down also get frame-based auto-repeat (DAS/ARR) timed by the 60 Hz `tick_game` strobe.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive clk cycles a synchronized input must differ from its debounced state before that state flips; legal range 1..2^20-1.
- `DAS_FRAMES`, default 10: ticks from the initial left/right press to the first repeat pulse; legal range 1..255.
- `ARR_FRAMES`, default 2: ticks between left/right repeat pulses; legal range 1..255.
- `SOFT_DROP_FRAMES`, default 3: ticks between down repeat pulses; legal range 1..255.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `tick_game` in 1: one-clk strobe at 60 Hz.
- `btn_left`, `btn_right`, `btn_down`, `btn_rotate`, `btn_drop`, `btn_hold` in 1 each: raw buttons, asynchronous, 1 = pressed.
- `key_left`, `key_right`, `key_down`, `key_rotate`, `key_drop`, `key_hold` out 1 each: one-clk pulses, registered.
- `key_drop_held` out 1: debounced level of `btn_drop`, registered.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer reset to 0.
- **Debounce:** each button has a 20-bit counter and a debounced state `db`.
  - While sync ≠ `db`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, `db` flips and the counter clears.
  - Any cycle with sync == `db` clears the counter, so a glitch shorter than `DEBOUNCE_CYCLES` never changes `db`.
- **Edge-only keys (rotate, drop, hold):** the key pulses for one cycle on each 0→1 transition of `db`. Holding the button generates nothing further.
- **`key_drop_held`:** a registered copy of `db_drop`.
- **Left/right:** each direction runs its own FSM with states IDLE, DAS and REPEAT, and an 8-bit tick counter.
  - IDLE → DAS on a `db` rise. The key pulses immediately and the counter is set to 0.
  - DAS: the counter increments on `tick_game`. The tick on which the count would reach `DAS_FRAMES` produces a pulse, clears the counter, and moves the FSM to REPEAT.
  - REPEAT: same counting rule, but the threshold is `ARR_FRAMES`, and the FSM stays in REPEAT.
  - A `db` fall forces IDLE from any state, with the counter cleared.
- **Left/right conflict (newest press wins):** a `db` rise on one direction forces the other FSM to IDLE with no pulse.
  - The suppressed direction stays IDLE until its own `db` falls and rises again.
  - On simultaneous rises in the same cycle, left is taken and right is suppressed.
- **Down:** a two-state FSM, IDLE and REPEAT.
  - On a rise it pulses, moves to REPEAT and sets the counter to 0.
  - In REPEAT it pulses every `SOFT_DROP_FRAMES` ticks.
  - On a fall it returns to IDLE.
- Pulses on different keys may coincide; the game FSM applies priority.

## Timing
- **Reset values:** every output is 0, all `db` are 0, all FSMs are IDLE, and all counters are 0. Reset acts immediately and asynchronously, including in the middle of a DAS or a repeat.
- **Buttons held through reset:** such a button is treated as a fresh press after reset deasserts. Its pulse appears `DEBOUNCE_CYCLES`+3 clocks later.
- **Press latency:** if a raw press is stable from before edge 0, the key pulse is high during the cycle that follows edge `DEBOUNCE_CYCLES`+3, for exactly one cycle.
- **Release latency:** `key_drop_held` falls `DEBOUNCE_CYCLES`+3 edges after a stable raw release.
- **Repeat pulses:** a repeat pulse is high in the cycle immediately after the qualifying `tick_game` cycle.
- **Release versus pending repeat:** if a `db` fall and a qualifying tick occur in the same cycle, the fall wins and no pulse is issued.
- **Counters:** the 8-bit tick counters cannot wrap because each clears at its threshold.

## Test plan
Unless a scenario says otherwise, the bench uses `DEBOUNCE_CYCLES`=4, `DAS_FRAMES`=10, `ARR_FRAMES`=2, `SOFT_DROP_FRAMES`=3, with `tick_game` every 20 clk.

1. **Reset:** assert `rst` asynchronously between edges with all buttons at 0 → all outputs are 0 immediately; release `rst` → outputs stay 0 for 1000 cycles.
2. **Rotate press and hold:** hold `btn_rotate` from edge 0 for 500 cycles → `key_rotate` is high only in the cycle after edge 7, with no further pulses. Then release `btn_rotate` and press again → exactly one new pulse.
3. **Glitch rejection:** pulse `btn_hold` high for 3 cycles, then low → `key_hold` never asserts. A 5-cycle pulse → one `key_hold` pulse.
4. **Left auto-repeat:** hold `btn_left` for 20 ticks → pulses at the press, at the 10th tick after the press, then on ticks 12, 14, 16, 18 and 20, for 7 pulses total. On release, no further pulses.
5. **Left/right conflict and soft drop:**
   - Hold left through DAS, then press right → `key_right` pulses and `key_left` repeats stop.
   - Release right while still holding left → no `key_left` pulse for 30 ticks.
   - Hold `btn_down` for 9 ticks → 4 `key_down` pulses.
6. **Drop with mid-hold reset:** hold `btn_drop` → one `key_drop` pulse and `key_drop_held`=1 while held.
   - Assert `rst` mid-hold → `key_drop_held`=0 at once.
   - Deassert `rst` with the button still held → `key_drop` pulses again 7 cycles later and `key_drop_held` returns to 1.
